intersection_scheduler: RTL and testbench

Two-road intersection sequencer with pedestrian phase. Drives two three-lamp signal heads (north-south, east-west) and a walk lamp. Phases are timed by a shared down-counter; greens extend on demand; a latched pedestrian request inserts a walk phase between directions. Sits above the per-head lamp logic and is the single point deciding which direction owns the crossing.

---
 rtl/intersection_pkg.sv | 28 ++
 rtl/intersection_scheduler_phase_timer.sv | 30 +++
 rtl/intersection_scheduler.sv | 173 +++++++++++++++++
 tb/tb_intersection_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/intersection_pkg.sv
// Shared phase encodings, default durations and lamp vectors
// for the two-road intersection scheduler.
package intersection_pkg;

    typedef enum logic [2:0] {
        PH_ALL_RED   = 3'd0,
        PH_NS_GREEN  = 3'd1,
        PH_NS_YELLOW = 3'd2,
        PH_EW_GREEN  = 3'd3,
        PH_EW_YELLOW = 3'd4,
        PH_PED_WALK  = 3'd5
    } phase_e;

    localparam int DEF_TW            = 8;
    localparam int DEF_GREEN_CYCLES  = 16;
    localparam int DEF_YELLOW_CYCLES = 4;
    localparam int DEF_ALLRED_CYCLES = 2;
    localparam int DEF_PED_CYCLES    = 8;

    // Lamp vectors are ordered {red, yellow, green}.
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Loadable saturating down-counter that times each phase;
// done is high while the count sits at zero.
module phase_timer
    import intersection_pkg::*;
#(
    parameter int            TW          = DEF_TW,
    parameter logic [TW-1:0] RESET_VALUE = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    output logic          done
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection sequencer: owns the crossing, sequences
// greens, yellows, clearance and an on-demand pedestrian walk.
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int TW            = DEF_TW,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int ALLRED_CYCLES = DEF_ALLRED_CYCLES,
    parameter int PED_CYCLES    = DEF_PED_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    input  logic       emergency,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ped_walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_CYCLES - 1);
    localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] ALLRED_LOAD = TW'(ALLRED_CYCLES - 1);
    localparam logic [TW-1:0] PED_LOAD    = TW'(PED_CYCLES - 1);

    phase_e        state;
    phase_e        state_next;
    logic          next_dir;
    logic          next_dir_nx;
    logic          ped_pending;
    logic          ped_pending_nx;
    logic          done;
    logic          load;
    logic [TW-1:0] load_value;
    logic [2:0]    ns_lamp;
    logic [2:0]    ew_lamp;
    logic [2:0]    ns_lamp_nx;
    logic [2:0]    ew_lamp_nx;
    logic          ped_walk_nx;
    logic          ped_ack_nx;

    phase_timer #(
        .TW          (TW),
        .RESET_VALUE (ALLRED_LOAD)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .done       (done)
    );

    always_comb begin
        state_next  = state;
        next_dir_nx = next_dir;
        case (state)
            PH_ALL_RED: begin
                if (done && !emergency) begin
                    if (ped_pending) begin
                        state_next = PH_PED_WALK;
                    end else if (next_dir == DIR_EW) begin
                        state_next = PH_EW_GREEN;
                    end else begin
                        state_next = PH_NS_GREEN;
                    end
                end
            end
            PH_NS_GREEN: begin
                // Green extends until someone else is waiting.
                if (emergency || (done && (ew_req || ped_pending))) begin
                    state_next = PH_NS_YELLOW;
                end
            end
            PH_NS_YELLOW: begin
                if (done) begin
                    state_next  = PH_ALL_RED;
                    next_dir_nx = DIR_EW;
                end
            end
            PH_EW_GREEN: begin
                if (emergency || (done && (ns_req || ped_pending))) begin
                    state_next = PH_EW_YELLOW;
                end
            end
            PH_EW_YELLOW: begin
                if (done) begin
                    state_next  = PH_ALL_RED;
                    next_dir_nx = DIR_NS;
                end
            end
            PH_PED_WALK: begin
                if (emergency || done) begin
                    state_next = PH_ALL_RED;
                end
            end
            default: begin
                state_next = PH_ALL_RED;
            end
        endcase
    end

    always_comb begin
        load       = (state_next != state);
        load_value = ALLRED_LOAD;
        case (state_next)
            PH_NS_GREEN,
            PH_EW_GREEN:  load_value = GREEN_LOAD;
            PH_NS_YELLOW,
            PH_EW_YELLOW: load_value = YELLOW_LOAD;
            PH_PED_WALK:  load_value = PED_LOAD;
            default:      load_value = ALLRED_LOAD;
        endcase
    end

    always_comb begin
        ns_lamp_nx  = LAMP_RED;
        ew_lamp_nx  = LAMP_RED;
        ped_walk_nx = 1'b0;
        case (state_next)
            PH_NS_GREEN:  ns_lamp_nx  = LAMP_GREEN;
            PH_NS_YELLOW: ns_lamp_nx  = LAMP_YELLOW;
            PH_EW_GREEN:  ew_lamp_nx  = LAMP_GREEN;
            PH_EW_YELLOW: ew_lamp_nx  = LAMP_YELLOW;
            PH_PED_WALK:  ped_walk_nx = 1'b1;
            default:      ped_walk_nx = 1'b0;
        endcase
    end

    // Entering the walk phase both acknowledges and clears the request.
    always_comb begin
        ped_ack_nx     = (state_next == PH_PED_WALK)
                      && (state != PH_PED_WALK);
        ped_pending_nx = ped_pending;
        if (ped_ack_nx) begin
            ped_pending_nx = 1'b0;
        end else if (ped_req && (state != PH_PED_WALK)) begin
            ped_pending_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PH_ALL_RED;
            next_dir    <= DIR_NS;
            ped_pending <= 1'b0;
            ns_lamp     <= LAMP_RED;
            ew_lamp     <= LAMP_RED;
            ped_walk    <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            state       <= state_next;
            next_dir    <= next_dir_nx;
            ped_pending <= ped_pending_nx;
            ns_lamp     <= ns_lamp_nx;
            ew_lamp     <= ew_lamp_nx;
            ped_walk    <= ped_walk_nx;
            ped_ack     <= ped_ack_nx;
        end
    end

    assign {ns_red, ns_yellow, ns_green} = ns_lamp;
    assign {ew_red, ew_yellow, ew_green} = ew_lamp;
    assign phase = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler with a free-running
// lamp-invariant monitor alongside the scripted sequence.
module tb_intersection_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       emergency = 1'b0;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       ped_walk, ped_ack;
    logic [2:0] phase;

    int compared = 0;
    int mismatched = 0;
    bit armed = 1'b0;

    intersection_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .ns_req    (ns_req),
        .ew_req    (ew_req),
        .ped_req   (ped_req),
        .emergency (emergency),
        .ns_red    (ns_red),
        .ns_yellow (ns_yellow),
        .ns_green  (ns_green),
        .ew_red    (ew_red),
        .ew_yellow (ew_yellow),
        .ew_green  (ew_green),
        .ped_walk  (ped_walk),
        .ped_ack   (ped_ack),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks phase at the current cycle, then advances, n times.
    task automatic hold(input string tag, input logic [2:0] ph,
                        input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, {29'd0, phase}, {29'd0, ph});
            tick(1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ns_req = 1'b0;
        ew_req = 1'b0;
        ped_req = 1'b0;
        emergency = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase"}, {29'd0, phase}, 32'd0);
        chk({tag, "_ns"}, {29'd0, ns_red, ns_yellow, ns_green}, 32'h4);
        chk({tag, "_ew"}, {29'd0, ew_red, ew_yellow, ew_green}, 32'h4);
        chk({tag, "_walk"}, {30'd0, ped_walk, ped_ack}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("inv_ns", {31'd0, $onehot({ns_red, ns_yellow, ns_green})},
                32'd1);
            chk("inv_ew", {31'd0, $onehot({ew_red, ew_yellow, ew_green})},
                32'd1);
            chk("inv_walk", {31'd0, ped_walk && !(ns_red && ew_red)},
                32'd0);
            chk("inv_phase", {31'd0, phase > 3'd5}, 32'd0);
        end
    end

    initial begin
        // Basic cycle with ew_req held.
        tick(1);
        armed = 1'b1;
        do_reset();
        ew_req = 1'b1;
        chk_reset_vals("rst1");
        hold("t1_ar", 3'd0, 2);
        hold("t1_nsg", 3'd1, 16);
        chk("t1_nsy_lamp", {29'd0, ns_red, ns_yellow, ns_green}, 32'h2);
        hold("t1_nsy", 3'd2, 4);
        hold("t1_ar2", 3'd0, 2);
        chk("t1_ewg_lamp", {26'd0, ns_red, ns_yellow, ns_green,
            ew_red, ew_yellow, ew_green}, 32'h21);
        hold("t1_ewg", 3'd3, 50);

        // Idle: NS green holds forever.
        do_reset();
        hold("t2_ar", 3'd0, 2);
        hold("t2_nsg", 3'd1, 198);
        chk("t2_phase200", {29'd0, phase}, 32'd1);
        chk("t2_lamps", {30'd0, ns_green, ew_red}, 32'h3);

        // Pedestrian pulse during NS green.
        do_reset();
        hold("t3_ar", 3'd0, 2);
        hold("t3_nsg", 3'd1, 5);
        ped_req = 1'b1;
        hold("t3_nsg5", 3'd1, 1);
        ped_req = 1'b0;
        hold("t3_nsgb", 3'd1, 10);
        hold("t3_nsy", 3'd2, 4);
        hold("t3_ar", 3'd0, 2);
        for (int i = 0; i < 8; i++) begin
            chk("t3_walk_ph", {29'd0, phase}, 32'd5);
            chk("t3_walk", {31'd0, ped_walk}, 32'd1);
            chk("t3_ack", {31'd0, ped_ack}, (i == 0) ? 32'd1 : 32'd0);
            tick(1);
        end
        chk("t3_walk_off", {30'd0, ped_walk, ped_ack}, 32'd0);
        hold("t3_ar2", 3'd0, 2);
        hold("t3_ewg", 3'd3, 20);

        // Emergency at NS green cycle 3 for 20 cycles.
        do_reset();
        hold("t4_ar", 3'd0, 2);
        hold("t4_nsg", 3'd1, 3);
        emergency = 1'b1;
        hold("t4_nsg3", 3'd1, 1);
        hold("t4_nsy", 3'd2, 4);
        hold("t4_ar", 3'd0, 15);
        emergency = 1'b0;
        hold("t4_rel", 3'd0, 1);
        hold("t4_ewg", 3'd3, 5);

        // Reset during EW yellow cycle 2.
        do_reset();
        ew_req = 1'b1;
        ns_req = 1'b1;
        hold("t5_ar", 3'd0, 2);
        hold("t5_nsg", 3'd1, 16);
        hold("t5_nsy", 3'd2, 4);
        hold("t5_ar2", 3'd0, 2);
        hold("t5_ewg", 3'd3, 16);
        hold("t5_ewy", 3'd4, 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_reset_vals("rst5");
        hold("t5_ar3", 3'd0, 2);
        chk("t5_nsg_again", {29'd0, phase}, 32'd1);

        // Cross request in last min-green cycle, then a late request.
        do_reset();
        hold("t6_ar", 3'd0, 2);
        hold("t6_nsg", 3'd1, 15);
        ew_req = 1'b1;
        hold("t6_last", 3'd1, 1);
        hold("t6_nsy", 3'd2, 1);
        do_reset();
        hold("t7_ar", 3'd0, 2);
        hold("t7_nsg", 3'd1, 25);
        ew_req = 1'b1;
        hold("t7_late", 3'd1, 1);
        hold("t7_nsy", 3'd2, 1);

        // Emergency cuts a walk phase short.
        do_reset();
        ped_req = 1'b1;
        tick(1);
        ped_req = 1'b0;
        hold("t8_ar", 3'd0, 1);
        hold("t8_walk", 3'd5, 3);
        emergency = 1'b1;
        hold("t8_walk3", 3'd5, 1);
        hold("t8_ar2", 3'd0, 3);

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
